// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the control sequencer: FSM states,
// opcode map and ALU source-select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IMM,
    S_IO_IN,
    S_IO_OUT,
    S_HALT
  } state_e;

  // Opcodes double as bit positions in the one-hot decode.
  // OP_MOV is the base of the 01xx group; the low two bits pick the register.
  localparam int OP_IN   = 'b0000;
  localparam int OP_OUT  = 'b0001;
  localparam int OP_MOVI = 'b0010;
  localparam int OP_HALT = 'b0011;
  localparam int OP_MOV  = 'b0100;
  localparam int OP_ADD  = 'b1000;
  localparam int OP_SUB  = 'b1001;
  localparam int OP_JMP  = 'b1010;
  localparam int OP_JG   = 'b1011;

  // Opcode bits at or above this position make an instruction illegal.
  localparam int LEGAL_W = 4;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_IMM  = 2'b11;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Handshake and strobe bundle between the sequencer (master) and the
// memory/IR/datapath side (slave). mem_imm_q travels with the bundle for the
// datapath's benefit; the sequencer only times its capture.
interface ctrl_sequencer_if #(
  parameter int OPW = 4
);
  logic              run;
  logic              step_mode;
  logic [OPW-1:0]    mem_q;
  logic [7:0]        mem_imm_q;
  logic              flag_gt;
  logic              in_valid;
  logic              out_ready;

  logic              mem_rd;
  logic              ir_load;
  logic              pc_inc;
  logic              pc_load;
  logic              reg_we;
  logic [1:0]        reg_sel;
  logic [1:0]        alu_sel;
  logic              in_ready;
  logic              out_valid;
  logic [2**OPW-1:0] dec;
  logic              halted;
  logic              err;

  modport master (
    input  run, step_mode, mem_q, mem_imm_q, flag_gt, in_valid, out_ready,
    output mem_rd, ir_load, pc_inc, pc_load, reg_we, reg_sel, alu_sel,
           in_ready, out_valid, dec, halted, err
  );

  modport slave (
    output run, step_mode, mem_q, mem_imm_q, flag_gt, in_valid, out_ready,
    input  mem_rd, ir_load, pc_inc, pc_load, reg_we, reg_sel, alu_sel,
           in_ready, out_valid, dec, halted, err
  );
endinterface

// File: rtl/ins_dec_onehot.sv
// Combinational opcode decoder: one-hot over the full opcode space plus a
// flag for opcodes with any bit set above the legal 4-bit field.
module ins_dec_onehot
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0]    op,
  output logic [2**OPW-1:0] onehot,
  output logic              illegal
);

  // One-hot expansion and illegal-range detect.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    onehot     = '0;
    onehot[op] = 1'b1;
    illegal    = (op >> LEGAL_W) != '0;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit-opcode CPU.
// State, wait counter, IR and registered decode live in one flop block;
// strobes are decoded from the current state and registered decode.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_sequencer_if.master bus
);

  localparam int               DW        = 2**OPW;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

  state_e           state_q, state_d, instr_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]   ir_q, ir_d;
  logic [DW-1:0]    dec_q, dec_d, dec_raw;
  logic             ill_q, ill_d, ill_raw;
  logic             wait_last;
  logic             is_mov, is_add, is_sub, is_jmp, is_jg;
  logic             is_in, is_out, is_movi, is_halt;

  ins_dec_onehot #(.OPW(OPW)) u_dec (
    .op      (ir_q),
    .onehot  (dec_raw),
    .illegal (ill_raw)
  );

  assign wait_last  = (cnt_q == WAIT_LAST);
  assign instr_next = bus.step_mode ? S_IDLE : S_FETCH;

  assign is_mov  = |dec_q[OP_MOV +: 4];
  assign is_add  = dec_q[OP_ADD];
  assign is_sub  = dec_q[OP_SUB];
  assign is_jmp  = dec_q[OP_JMP];
  assign is_jg   = dec_q[OP_JG];
  assign is_in   = dec_q[OP_IN];
  assign is_out  = dec_q[OP_OUT];
  assign is_movi = dec_q[OP_MOVI];
  assign is_halt = dec_q[OP_HALT];

  // Next state, wait counter, IR capture and decode capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    dec_d   = dec_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: if (bus.run) begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: if (wait_last) begin
        ir_d    = bus.mem_q;
        state_d = S_DECODE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_DECODE: begin
        dec_d   = dec_raw;
        ill_d   = ill_raw;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = '0;
        if (is_movi)      state_d = S_IMM;
        else if (is_in)   state_d = S_IO_IN;
        else if (is_out)  state_d = S_IO_OUT;
        else if (is_halt) state_d = S_HALT;
        else              state_d = instr_next;
      end
      S_IMM: if (wait_last) begin
        state_d = instr_next;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_IO_IN:  if (bus.in_valid)  state_d = instr_next;
      S_IO_OUT: if (bus.out_ready) state_d = instr_next;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencer registers; reset drops every strobe without delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      dec_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      dec_q   <= dec_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.dec = dec_q;

  // Datapath strobes from state and registered decode.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.ir_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_sel   = 2'b00;
    bus.alu_sel   = ALU_PASS;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.halted    = 1'b0;
    bus.err       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_rd  = 1'b1;
        bus.ir_load = wait_last;
        bus.pc_inc  = wait_last;
      end
      S_EXEC: begin
        if (ill_q) begin
          bus.err = 1'b1;
        end else if (is_mov) begin
          bus.reg_we  = 1'b1;
          bus.reg_sel = ir_q[1:0];
          bus.alu_sel = ALU_PASS;
        end else if (is_add) begin
          bus.reg_we  = 1'b1;
          bus.alu_sel = ALU_ADD;
        end else if (is_sub) begin
          bus.reg_we  = 1'b1;
          bus.alu_sel = ALU_SUB;
        end else if (is_jmp) begin
          bus.pc_load = 1'b1;
        end else if (is_jg) begin
          bus.pc_load = bus.flag_gt;
        end
      end
      S_IMM: begin
        bus.mem_rd = 1'b1;
        if (wait_last) begin
          bus.reg_we  = 1'b1;
          bus.alu_sel = ALU_IMM;
          bus.pc_inc  = 1'b1;
        end
      end
      S_IO_IN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.reg_we  = 1'b1;
          bus.alu_sel = ALU_IMM;
        end
      end
      S_IO_OUT: bus.out_valid = 1'b1;
      S_HALT:   bus.halted    = 1'b1;
      default: ;
    endcase
  end

endmodule
